program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Parametrised boot/program loader for the RISC CPU. Accepts a word stream on a valid/ready
//  handshake, writes it sequentially into CPU memory from address 0, verifies a trailing
//  checksum word, and holds the CPU in reset-hold until a clean image is in place.
//  Successor to the fixed 8-bit/32-word Load-pin scheme: adds back-pressure, checksum,
//  abort and error reporting.
// PARAMETERS
//  DATA_W      8   memory word / instruction width
//  ADDR_W      5   memory address width; image length = 2**ADDR_W words
//  CHECKSUM_EN 1   1: expect one checksum word after the image; 0: no checksum phase
// PORTS
//  clock       in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  load_start  in   1       pulse: begin a new load (accepted in IDLE, DONE, ERROR)
//  load_abort  in   1       pulse: cancel an in-progress load
//  in_valid    in   1       data_in carries a word
//  in_ready    out  1       loader accepts a word this cycle
//  data_in     in   DATA_W  image word
//  mem_we      out  1       memory write strobe (one cycle per accepted image word)
//  mem_addr    out  ADDR_W  write address
//  mem_wdata   out  DATA_W  write data
//  cpu_hold    out  1       1: CPU must stay halted/PC at 0
//  load_done   out  1       image loaded and verified
//  load_error  out  1       checksum mismatch or abort
//  word_count  out  ADDR_W+1 words accepted in current load
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   cpu_hold=1, load_done=0, load_error=0, word_count=0, checksum accumulator=0.
//  States: IDLE, LOAD, CHECK, DONE, ERROR.
//   IDLE : cpu_hold=1. load_start -> LOAD, clear addr/count/accumulator/flags.
//   LOAD : in_ready=1. Beat = in_valid&in_ready. Each beat registers mem_we=1,
//          mem_addr=addr, mem_wdata=data_in (write visible one cycle after beat);
//          addr++, word_count++, acc = acc + data_in (mod 2**DATA_W).
//          Beat on last address (2**ADDR_W-1): -> CHECK if CHECKSUM_EN else -> DONE.
//          addr never wraps within a load; no beats accepted beyond last word.
//   CHECK: in_ready=1, mem_we=0. Beat: if (acc + data_in) mod 2**DATA_W == 0 -> DONE,
//          else -> ERROR. Checksum word is never written to memory.
//   DONE : in_ready=0, cpu_hold=0, load_done=1 (level, held). load_start -> LOAD (re-hold CPU
//          the cycle after).
//   ERROR: in_ready=0, cpu_hold=1, load_error=1 (level). load_start -> LOAD.
//  load_abort in LOAD/CHECK -> ERROR next cycle; any same-cycle beat is discarded (no write).
//  load_abort in IDLE/DONE/ERROR ignored. load_abort and load_start together: abort wins.
//  load_start in LOAD/CHECK ignored. in_valid outside LOAD/CHECK ignored, in_ready=0.
//  Gaps (in_valid=0) stall indefinitely; no timeout. data_in need only be stable on beats.
//  mem_we is a single-cycle pulse; mem_addr/mem_wdata hold last values when mem_we=0.
//  cpu_hold rises combinationally-free: registered, asserted the cycle after leaving DONE.
//  Reset mid-load returns to IDLE; partially written memory is not cleared.
// STRUCTURE
//  Shared package cpu_pkg: loader state encoding (localparam/enum), DATA_W/ADDR_W defaults
//   shared with CPU, memory and PC widths.
//  Single module; no sub-module. Checksum adder inline (DATA_W-bit wrap add).
// TESTING
//  1 Defaults, 32-word image (word0=8'hFE ... word31=8'h00) + correct checksum, in_valid
//    continuous -> 32 mem_we pulses addr 0..31, load_done=1, cpu_hold=0 after 34th cycle.
//  2 Same image, checksum off by 1 -> no 33rd write, load_error=1, cpu_hold stays 1.
//  3 in_valid toggled 1-0-1 randomly -> identical memory contents and word_count=32.
//  4 load_abort asserted with word_count=10 and in_valid=1 -> ERROR, only addr 0..9 written;
//    then load_start -> fresh load from addr 0 succeeds.
//  5 reset=0 pulse mid-LOAD at word 20 -> all outputs at reset values immediately;
//    load_start afterward restarts at addr 0.
//  6 CHECKSUM_EN=0, ADDR_W=3, DATA_W=16 -> 8 writes then DONE, no checksum beat consumed.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Widths shared by the RISC CPU, its memory, PC and the program
//               loader, plus the program loader state encoding.
// Contents    : CPU_DATA_W  - instruction / memory word width
//               CPU_ADDR_W  - memory address width (image = 2**CPU_ADDR_W words)
//               CPU_PC_W    - program counter width (spans the memory)
//               loader_state_t - program loader FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 5;
    localparam int CPU_PC_W   = CPU_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot/program loader. Takes an image word stream over a
//               valid/ready handshake, writes it to CPU memory from address 0,
//               verifies an optional trailing checksum word and holds the CPU
//               halted until a clean image is in place.
// Ports       : clock       - system clock, rising edge
//               reset       - asynchronous active-low reset
//               load_start  - pulse: begin a new load (IDLE/DONE/ERROR)
//               load_abort  - pulse: cancel an in-progress load
//               in_valid    - data_in carries a word
//               in_ready    - loader accepts a word this cycle
//               data_in     - image / checksum word
//               mem_we      - memory write strobe, one cycle per image word
//               mem_addr    - memory write address
//               mem_wdata   - memory write data
//               cpu_hold    - 1: CPU must stay halted with PC at 0
//               load_done   - image loaded and verified (level)
//               load_error  - checksum mismatch or abort (level)
//               word_count  - image words accepted in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import cpu_pkg::*;
#(
    parameter int DATA_W      = CPU_DATA_W,
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int CHECKSUM_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;
    logic              beat;
    logic              start_ok;

    assign in_ready = (state == ST_LOAD) || (state == ST_CHECK);
    // An abort discards any beat offered in the same cycle.
    assign beat     = in_valid && in_ready && !load_abort;
    assign start_ok = load_start &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    // Wrapping add: the image plus its checksum word must sum to zero.
    assign acc_sum  = acc + data_in;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_abort)
                    state_nxt = ST_ERROR;
                else if (beat && (addr == LAST_ADDR))
                    state_nxt = (CHECKSUM_EN != 0) ? ST_CHECK : ST_DONE;
            end
            ST_CHECK: begin
                if (load_abort)
                    state_nxt = ST_ERROR;
                else if (beat)
                    state_nxt = (acc_sum == '0) ? ST_DONE : ST_ERROR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            acc        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            mem_we     <= 1'b0;
            // Status flags are registered from the next state so they change
            // together with the state itself; the CPU is re-held the cycle
            // after a new load leaves DONE.
            cpu_hold   <= (state_nxt != ST_DONE);
            load_done  <= (state_nxt == ST_DONE);
            load_error <= (state_nxt == ST_ERROR);

            if (start_ok) begin
                addr       <= '0;
                acc        <= '0;
                word_count <= '0;
            end

            if ((state == ST_LOAD) && beat) begin
                mem_we     <= 1'b1;
                mem_addr   <= addr;
                mem_wdata  <= data_in;
                acc        <= acc_sum;
                word_count <= word_count + (ADDR_W+1)'(1);
                // Address saturates at the last word; the state leaves LOAD
                // on that beat so nothing further is written.
                if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
